// File: rtl/posit64_encode_if.sv
// posit64_encode_if: input-tuple and output-posit handshake bundle for posit64_encode
interface posit64_encode_if;
    logic        in_valid;
    logic        in_ready;
    logic        in_zero;
    logic        in_nar;
    logic        in_sign;
    logic [63:0] in_regime;
    logic [63:0] in_exponent;
    logic [63:0] in_fraction;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_p;

    modport master (
        output in_valid, in_zero, in_nar, in_sign, in_regime, in_exponent, in_fraction, out_ready,
        input  in_ready, out_valid, out_p
    );

    modport slave (
        input  in_valid, in_zero, in_nar, in_sign, in_regime, in_exponent, in_fraction, out_ready,
        output in_ready, out_valid, out_p
    );
endinterface

// File: rtl/posit64_encode.sv
// posit64_encode: 3-stage posit64 encoder (classify, assemble, round/negate); RNE when POSIT_ENCODE_RNE_EN is defined
module posit64_encode #(
    parameter int es = 2
) (
    input logic            clk,
    input logic            rst_n,
    posit64_encode_if.slave bus
);
    localparam int NW = 129 + es;

    logic rdy1, rdy2, rdy3;

    logic          s1_v_q, s1_zero_q, s1_nar_q, s1_sign_q, s1_smax_q, s1_smin_q, s1_neg_q;
    logic [5:0]    s1_sh_q;
    logic [es-1:0] s1_exp_q;
    logic [63:0]   s1_frac_q;
    logic          s1_smax_d, s1_smin_d;
    logic [5:0]    s1_sh_d;

    logic          s2_v_q, s2_zero_q, s2_nar_q, s2_sign_q, s2_smax_q, s2_smin_q, s2_g_q, s2_st_q;
    logic [62:0]   s2_mag_q;
    logic [62:0]   s2_mag_d;
    logic          s2_g_d, s2_st_d;

    logic          out_valid_q;
    logic [63:0]   out_p_q, out_p_d;

    logic signed [NW-1:0] sv_w;
    logic [NW-2:0]        sh_w;
    logic [63:0]          rnd_w;
    logic [62:0]          m_w;
    logic                 unused_exp;

    // A stage may load when it is empty or its content moves on this cycle
    assign rdy3         = !out_valid_q || bus.out_ready;
    assign rdy2         = !s2_v_q || rdy3;
    assign rdy1         = !s1_v_q || rdy2;
    assign bus.in_ready = rdy1;
    assign unused_exp   = ^bus.in_exponent[63:es];

    // Regime run minus one: k>=0 -> k+1 leading ones, k<0 -> -k leading zeros
    assign s1_smax_d = $signed(bus.in_regime) >= 64'sd62;
    assign s1_smin_d = $signed(bus.in_regime) <= -64'sd63;
    assign s1_sh_d   = bus.in_regime[63] ? 6'(-bus.in_regime) : 6'(bus.in_regime + 64'd1);

    // S1: capture classified tuple
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v_q    <= 1'b0;
            s1_zero_q <= 1'b0;
            s1_nar_q  <= 1'b0;
            s1_sign_q <= 1'b0;
            s1_smax_q <= 1'b0;
            s1_smin_q <= 1'b0;
            s1_neg_q  <= 1'b0;
            s1_sh_q   <= '0;
            s1_exp_q  <= '0;
            s1_frac_q <= '0;
        end else if (rdy1) begin
            s1_v_q <= bus.in_valid;
            if (bus.in_valid) begin
                s1_zero_q <= bus.in_zero;
                s1_nar_q  <= bus.in_nar;
                s1_sign_q <= bus.in_sign;
                s1_smax_q <= s1_smax_d;
                s1_smin_q <= s1_smin_d;
                s1_neg_q  <= bus.in_regime[63];
                s1_sh_q   <= s1_sh_d;
                s1_exp_q  <= bus.in_exponent[es-1:0];
                s1_frac_q <= bus.in_fraction;
            end
        end
    end

    // Arithmetic shift replicates the leading regime bit; the dropped top bit leaves run-1 copies before the terminator
    assign sv_w     = {~s1_neg_q, s1_neg_q, s1_exp_q, s1_frac_q, 63'd0};
    assign sh_w     = (NW-1)'(sv_w >>> s1_sh_q);
    assign s2_mag_d = sh_w[NW-2 -: 63];
    assign s2_g_d   = sh_w[NW-65];
    assign s2_st_d  = |sh_w[NW-66:0];

    // S2: capture assembled magnitude with guard and sticky
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_v_q    <= 1'b0;
            s2_zero_q <= 1'b0;
            s2_nar_q  <= 1'b0;
            s2_sign_q <= 1'b0;
            s2_smax_q <= 1'b0;
            s2_smin_q <= 1'b0;
            s2_g_q    <= 1'b0;
            s2_st_q   <= 1'b0;
            s2_mag_q  <= '0;
        end else if (rdy2) begin
            s2_v_q <= s1_v_q;
            if (s1_v_q) begin
                s2_zero_q <= s1_zero_q;
                s2_nar_q  <= s1_nar_q;
                s2_sign_q <= s1_sign_q;
                s2_smax_q <= s1_smax_q;
                s2_smin_q <= s1_smin_q;
                s2_g_q    <= s2_g_d;
                s2_st_q   <= s2_st_d;
                s2_mag_q  <= s2_mag_d;
            end
        end
    end

`ifdef POSIT_ENCODE_RNE_EN
    assign rnd_w = {1'b0, s2_mag_q} + 64'(s2_g_q && (s2_st_q || s2_mag_q[0]));
`else
    logic unused_rnd;
    assign unused_rnd = s2_g_q ^ s2_st_q;
    assign rnd_w      = {1'b0, s2_mag_q};
`endif

    // Non-zero values stay inside [minpos, maxpos]; specials override, sign applied last
    assign m_w     = (s2_smax_q || rnd_w[63]) ? '1 :
                     (s2_smin_q || rnd_w[62:0] == 63'd0) ? 63'd1 : rnd_w[62:0];
    assign out_p_d = s2_nar_q  ? 64'h8000_0000_0000_0000 :
                     s2_zero_q ? 64'd0 :
                     s2_sign_q ? -{1'b0, m_w} : {1'b0, m_w};

    // S3: output register, held while downstream stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_p_q     <= '0;
        end else if (rdy3) begin
            out_valid_q <= s2_v_q;
            if (s2_v_q) out_p_q <= out_p_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_p     = out_p_q;
endmodule

// File: tb/tb_posit64_encode.sv
// tb_posit64_encode: directed vectors for posit64_encode (es=2), scoreboard on the output handshake
module tb_posit64_encode;
    typedef struct {
        logic        z, n, s;
        logic [63:0] k, e, f, p;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_tx = 0;
    int   n_rx = 0;
    logic [63:0] exp_q[$];
    vec_t tv[$];
    logic hold = 1'b0;
    logic [63:0] hold_p = '0;

    posit64_encode_if bus();

    posit64_encode #(.es(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, want);
        end
    endtask

    task automatic add(input logic z, input logic n, input logic s, input logic [63:0] k,
                       input logic [63:0] e, input logic [63:0] f, input logic [63:0] p);
        vec_t v;
        v.z = z; v.n = n; v.s = s; v.k = k; v.e = e; v.f = f; v.p = p;
        tv.push_back(v);
    endtask

    task automatic send(input vec_t v);
        logic ok;
        int t;
        bus.in_zero     = v.z;
        bus.in_nar      = v.n;
        bus.in_sign     = v.s;
        bus.in_regime   = v.k;
        bus.in_exponent = v.e;
        bus.in_fraction = v.f;
        bus.in_valid    = 1'b1;
        t = 0;
        do begin
            @(negedge clk);
            ok = bus.in_ready;
            @(posedge clk);
            #1;
            t++;
        end while (!ok && t < 200);
        if (!ok) chk("accept_timeout", 64'd0, 64'd1);
        else begin
            exp_q.push_back(v.p);
            n_tx++;
        end
        bus.in_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst_n) hold = 1'b0;
        else begin
            if (hold) begin
                chk("hold_valid", 64'(bus.out_valid), 64'd1);
                chk("hold_p", bus.out_p, hold_p);
            end
            hold   = bus.out_valid && !bus.out_ready;
            hold_p = bus.out_p;
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) chk("spurious_out", bus.out_p, 64'hDEAD_0000_0000_0000 ^ bus.out_p ^ bus.out_p);
                else chk($sformatf("out%0d", n_rx), bus.out_p, exp_q.pop_front());
                n_rx++;
            end
        end
    end

    initial begin
        bus.in_valid = 1'b0; bus.in_zero = 1'b0; bus.in_nar = 1'b0; bus.in_sign = 1'b0;
        bus.in_regime = '0; bus.in_exponent = '0; bus.in_fraction = '0; bus.out_ready = 1'b1;

        add(0, 0, 0, 64'd0,        64'd0, 64'd0, 64'h4000_0000_0000_0000);
        add(0, 0, 1, 64'd0,        64'd0, 64'd0, 64'hC000_0000_0000_0000);
        add(0, 0, 0, 64'd1,        64'd0, 64'd0, 64'h6000_0000_0000_0000);
        add(0, 0, 0, -64'sd1,      64'd0, 64'd0, 64'h2000_0000_0000_0000);
        add(0, 0, 0, 64'd100,      64'd0, 64'd0, 64'h7FFF_FFFF_FFFF_FFFF);
        add(0, 0, 0, -64'sd100,    64'd0, 64'd0, 64'h0000_0000_0000_0001);
        add(0, 1, 1, 64'd5,        64'd1, 64'd7, 64'h8000_0000_0000_0000);
        add(1, 0, 1, 64'd7,        64'd1, 64'd7, 64'h0000_0000_0000_0000);
        add(1, 1, 0, 64'd0,        64'd0, 64'd0, 64'h8000_0000_0000_0000);
        add(0, 0, 0, 64'd0,        64'd3, 64'd0, 64'h5800_0000_0000_0000);
`ifdef POSIT_ENCODE_RNE_EN
        add(0, 0, 0, 64'd0,        64'd0, 64'h30, 64'h4000_0000_0000_0002);
`else
        add(0, 0, 0, 64'd0,        64'd0, 64'h30, 64'h4000_0000_0000_0001);
`endif
        add(0, 0, 0, 64'd0,        64'd0, 64'h10, 64'h4000_0000_0000_0000);
        add(0, 0, 1, -64'sd100,    64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF);
`ifdef POSIT_ENCODE_RNE_EN
        add(0, 0, 0, 64'd61,       64'd3, 64'd0, 64'h7FFF_FFFF_FFFF_FFFF);
`else
        add(0, 0, 0, 64'd61,       64'd3, 64'd0, 64'h7FFF_FFFF_FFFF_FFFE);
`endif
        add(0, 0, 0, 64'd62,       64'd0, 64'd0, 64'h7FFF_FFFF_FFFF_FFFF);
`ifdef POSIT_ENCODE_RNE_EN
        add(0, 0, 0, -64'sd62,     64'd3, 64'd0, 64'h0000_0000_0000_0002);
`else
        add(0, 0, 0, -64'sd62,     64'd3, 64'd0, 64'h0000_0000_0000_0001);
`endif
        add(0, 0, 0, -64'sd63,     64'd0, 64'd0, 64'h0000_0000_0000_0001);
        add(0, 0, 0, 64'd2,        64'd1, 64'h8000_0000_0000_0000, 64'h7300_0000_0000_0000);
        add(0, 0, 1, 64'd2,        64'd1, 64'h8000_0000_0000_0000, 64'h8D00_0000_0000_0000);
        add(0, 0, 0, 64'd0,        64'hFFFF_FFFF_FFFF_FFFC, 64'd0, 64'h4000_0000_0000_0000);

        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out_p", bus.out_p, 64'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);

        send(tv[0]);
        chk("lat1_valid", 64'(bus.out_valid), 64'd0);
        @(posedge clk);
        #1;
        chk("lat2_valid", 64'(bus.out_valid), 64'd0);
        @(posedge clk);
        #1;
        chk("lat3_valid", 64'(bus.out_valid), 64'd1);
        chk("lat3_p", bus.out_p, 64'h4000_0000_0000_0000);
        repeat (2) @(posedge clk);
        #1;

        fork
            foreach (tv[i]) send(tv[i]);
            begin
                repeat (4) @(posedge clk);
                #1 bus.out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1 bus.out_ready = 1'b1;
            end
        join
        for (int i = 0; i < 100 && exp_q.size() > 0; i++) @(posedge clk);
        repeat (2) @(posedge clk);
        #1;
        chk("drain", 64'(exp_q.size()), 64'd0);
        chk("count", 64'(n_rx), 64'(n_tx));

        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(tv[i + 2]);
        #2 rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("midrst_valid", 64'(bus.out_valid), 64'd0);
        chk("midrst_p", bus.out_p, 64'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b1;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("postrst_valid%0d", i), 64'(bus.out_valid), 64'd0);
        end
        chk("postrst_in_ready", 64'(bus.in_ready), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
